// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: MEM-stage FSM states, Mem/WB field bit positions, default error data.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Mem control field: bit1 MemRead, bit0 MemWrite
  localparam int MEM_RD  = 1;
  localparam int MEM_WR  = 0;
  // WB control field: bit1 RegWrite, bit0 MemtoReg
  localparam int WB_REGW = 1;
  localparam int WB_M2R  = 0;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles of an outstanding data-memory access and flags the last allowed cycle.
// Latency: count is registered; tc_o decodes the current count combinationally.
// Backpressure: none; clear has priority over enable.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  // Count enabled cycles; clear returns to zero for the next access
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores over a req/ack data-memory port, results and pass-through fields to MEM/WB.
// Latency: 0 cycles for non-memory ops; k+1 stall cycles for ack after k BUSY cycles, 1 for misaligned, TIMEOUT+1 on timeout.
// Backpressure: stall_o holds the upstream pipeline while an access is outstanding; req is held stable until ack.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  Mem_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] alu_ans_i,
  input  logic [31:0] rtdata_i,
  input  logic [4:0]  WBreg_i,
  input  logic [31:0] pc_add4_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic [31:0] alu_ans_o,
  output logic [4:0]  WBreg_o,
  output logic [31:0] pc_add4_o,
  output logic [1:0]  WB_o,
  output logic        err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i
);

  mem_state_e  state_q, state_d;
  logic        req_q, we_q, rd_q, err_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic        pending, aligned, is_read, tc;

  assign pending = (Mem_i != 2'b00);
  assign aligned = (alu_ans_i[1:0] == 2'b00);
  // 2'b11 counts as a read, so the read bit alone decides direction
  assign is_read = Mem_i[MEM_RD];

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != ST_BUSY),
    .en_i  (state_q == ST_BUSY),
    .tc_o  (tc)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus stall/result outputs; ack outside BUSY is never looked at
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    rdata_o = '0;
    err_o   = 1'b0;
    WB_o    = WB_i;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          stall_o = 1'b1;
          state_d = aligned ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (dmem_ack_i || tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_o   = err_q;
        rdata_o = err_q ? ERR_DATA : data_q;
        if (err_q) begin
          WB_o = {1'b0, WB_i[WB_M2R]};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request launch/hold, response capture and error flag; ack beats the terminal count
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending && aligned) begin
            req_q   <= 1'b1;
            we_q    <= Mem_i[MEM_WR] & ~Mem_i[MEM_RD];
            rd_q    <= is_read;
            addr_q  <= alu_ans_i;
            wdata_q <= rtdata_i;
          end else if (pending) begin
            err_q  <= 1'b1;
            data_q <= '0;
          end
        end
        ST_BUSY: begin
          if (dmem_ack_i) begin
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            data_q <= rd_q ? dmem_rdata_i : '0;
          end else if (tc) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b1;
          end
        end
        ST_DONE: begin
          err_q  <= 1'b0;
          data_q <= '0;
        end
        default: begin
          req_q <= 1'b0;
          we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

  assign alu_ans_o = alu_ans_i;
  assign WBreg_o   = WBreg_i;
  assign pc_add4_o = pc_add4_i;

endmodule
